dmem_mmio_ctrl: RTL and testbench

Data-side memory subsystem that sits directly downstream of the nano_rv32i core's data port. It consumes the core's address, write data, read strobe and byte write enables, and it returns load data. It contains:
- a byte-addressable word RAM;
- a small MMIO window with a console transmit FIFO and a 32-bit timer with a compare interrupt.

Read data is registered with exactly one cycle of latency. This matches the core's single load stall cycle.

---
 rtl/dmem_mmio_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dmem_mmio_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_mmio_ctrl
//   Data-side memory subsystem for the nano_rv32i core. It decodes each access
//   from the core into one of three targets: a byte-addressable word RAM, a
//   small MMIO window, or "unmapped". The MMIO window holds a console TX FIFO
//   and a 32-bit timer with a compare interrupt. Load data is registered, so it
//   appears one cycle after the read request.
//
// Ports
//   clk_i        : single clock, all state updates on the rising edge
//   rst_i        : synchronous, active-high reset
//   d_addr_i     : byte address from core (low two bits ignored)
//   d_data_i     : lane-aligned store data
//   d_rd_i       : read request
//   d_we_i       : byte-lane write enables (any bit set = write)
//   d_data_o     : registered load data, held until the next read
//   d_err_o      : one-cycle pulse after an access to an unmapped address
//   con_data_o   : console FIFO head byte (0 when empty)
//   con_valid_o  : console FIFO not empty
//   con_ready_i  : console sink accepts the head byte
//   timer_irq_o  : registered mtime >= mtimecmp (unsigned)
// -----------------------------------------------------------------------------
module dmem_mmio_ctrl #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_rd_i,
    input  logic [3:0]  d_we_i,
    output logic [31:0] d_data_o,
    output logic        d_err_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic        timer_irq_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CON_TX   = 2'd0,
        REG_CON_STAT = 2'd1,
        REG_MTIME    = 2'd2,
        REG_MTIMECMP = 2'd3
    } mmio_reg_e;

    // ---------------------------------------------------------------- decode
    logic [31:0]   mmio_off;
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    mmio_reg_e     mmio_reg;
    logic          wr_any;
    logic          unused_off_bits;

    assign mmio_off        = d_addr_i - MMIO_BASE;
    assign ram_hit         = !d_addr_i[31] && (d_addr_i[30:AW+2] == '0);
    assign mmio_hit        = d_addr_i[31] && (mmio_off[31:4] == '0);
    assign ram_idx         = d_addr_i[AW+1:2];
    assign mmio_reg        = mmio_reg_e'(mmio_off[3:2]);
    assign wr_any          = |d_we_i;
    // Byte offset within a word is irrelevant: only word accesses exist.
    assign unused_off_bits = ^mmio_off[1:0];

    // ---------------------------------------------------------------- state
    logic [31:0] mem [MEM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [FW:0] wr_ptr, rd_ptr;
    logic        overflow;
    logic [31:0] mtime, mtimecmp;

    // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
    logic fifo_empty, fifo_full;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);

    assign con_valid_o = !fifo_empty;
    assign con_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[FW-1:0]];

    logic push_req, pop, push_ok, ovf_set, ovf_clr;
    logic mtime_wr, mtimecmp_wr;

    assign pop         = !fifo_empty && con_ready_i;
    assign push_req    = mmio_hit && (mmio_reg == REG_CON_TX) && d_we_i[0];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = push_req && (!fifo_full || pop);
    assign ovf_set     = push_req && fifo_full && !pop;
    assign ovf_clr     = mmio_hit && (mmio_reg == REG_CON_STAT) && d_we_i[0] && d_data_i[2];
    assign mtime_wr    = mmio_hit && (mmio_reg == REG_MTIME) && wr_any;
    assign mtimecmp_wr = mmio_hit && (mmio_reg == REG_MTIMECMP) && wr_any;

    // ---------------------------------------------------------------- comb
    logic [31:0] rdata;
    logic [31:0] mtime_nxt, mtimecmp_nxt;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rdata        = '0;
        mtime_nxt    = mtime + 32'd1;
        mtimecmp_nxt = mtimecmp;

        if (ram_hit) begin
            rdata = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_reg)
                REG_CON_TX:   rdata = '0;
                REG_CON_STAT: rdata = {29'b0, overflow, fifo_empty, fifo_full};
                REG_MTIME:    rdata = mtime;
                REG_MTIMECMP: rdata = mtimecmp;
                default:      rdata = '0;
            endcase
        end

        // Timer registers honour each byte lane; a write replaces the increment.
        if (mtime_wr) begin
            mtime_nxt = mtime;
            for (int i = 0; i < 4; i++)
                if (d_we_i[i]) mtime_nxt[8*i +: 8] = d_data_i[8*i +: 8];
        end
        if (mtimecmp_wr) begin
            for (int i = 0; i < 4; i++)
                if (d_we_i[i]) mtimecmp_nxt[8*i +: 8] = d_data_i[8*i +: 8];
        end
    end

    // ---------------------------------------------------------------- storage
    // NOTE: RAM and FIFO storage have no reset; the FIFO pointers alone define
    // which entries are valid, and reset-free arrays map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (ram_hit) begin
            for (int i = 0; i < 4; i++)
                if (d_we_i[i]) mem[ram_idx][8*i +: 8] <= d_data_i[8*i +: 8];
        end
        if (push_ok) fifo_mem[wr_ptr[FW-1:0]] <= d_data_i[7:0];
    end

    // ---------------------------------------------------------------- control
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values (this is what gives read-first RAM).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_data_o    <= '0;
            d_err_o     <= 1'b0;
            timer_irq_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            mtime       <= '0;
            mtimecmp    <= 32'hFFFF_FFFF;
        end else begin
            if (d_rd_i) d_data_o <= rdata;
            d_err_o     <= (d_rd_i || wr_any) && !(ram_hit || mmio_hit);
            timer_irq_o <= (mtime >= mtimecmp);
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            // Set has priority over a simultaneous clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio_ctrl
//   Directed bench for dmem_mmio_ctrl: RAM word/lane access, read-first
//   collision, unmapped-access errors, console FIFO overflow and drain, mid-
//   operation reset, and timer compare/wrap. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_ctrl;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] MB        = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic        d_rd_i;
    logic [3:0]  d_we_i;
    logic [31:0] d_data_o;
    logic        d_err_o;
    logic [7:0]  con_data_o;
    logic        con_valid_o;
    logic        con_ready_i;
    logic        timer_irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    dmem_mmio_ctrl #(
        .MEM_WORDS (MEM_WORDS),
        .MMIO_BASE (MB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .d_addr_i   (d_addr_i),
        .d_data_i   (d_data_i),
        .d_rd_i     (d_rd_i),
        .d_we_i     (d_we_i),
        .d_data_o   (d_data_o),
        .d_err_o    (d_err_o),
        .con_data_o (con_data_o),
        .con_valid_o(con_valid_o),
        .con_ready_i(con_ready_i),
        .timer_irq_o(timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    // One bus cycle: drive, take one rising edge, then return 1 time unit
    // later with the request removed so outputs can be sampled.
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] we, input logic rd);
        d_addr_i = a;
        d_data_i = d;
        d_we_i   = we;
        d_rd_i   = rd;
        @(posedge clk_i);
        #1;
        d_we_i = 4'h0;
        d_rd_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (d_data_o !== 32'h0) begin
            $display("FAIL reset_d_data: got %h want %h", d_data_o, 32'h0); n_miss++;
        end
        n_vec++;
        if ({d_err_o, timer_irq_o, con_valid_o} !== 3'b000) begin
            $display("FAIL reset_flags: got err/irq/valid=%b want 000",
                     {d_err_o, timer_irq_o, con_valid_o}); n_miss++;
        end
        n_vec++;
        if (con_data_o !== 8'h00) begin
            $display("FAIL reset_con_data: got %h want 00", con_data_o); n_miss++;
        end
        bus(MB + 32'h8, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h0) begin
            $display("FAIL reset_mtime: got %h want %h", d_data_o, 32'h0); n_miss++;
        end
    endtask

    task automatic test_ram();
        bus(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        n_vec++;
        if (d_data_o !== 32'h0) begin
            $display("FAIL ram_before_read: got %h want %h", d_data_o, 32'h0); n_miss++;
        end
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hDEAD_BEEF) begin
            $display("FAIL ram_word: got %h want %h", d_data_o, 32'hDEAD_BEEF); n_miss++;
        end
        bus(32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
        bus(32'h10, 32'h0000_CC00, 4'b0010, 1'b0);
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hDEAD_CCAA) begin
            $display("FAIL ram_lanes: got %h want %h", d_data_o, 32'hDEAD_CCAA); n_miss++;
        end
        // Read-first collision.
        bus(32'h20, 32'h0000_0001, 4'hF, 1'b0);
        bus(32'h20, 32'h1234_5678, 4'hF, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h0000_0001) begin
            $display("FAIL read_first_old: got %h want %h", d_data_o, 32'h1); n_miss++;
        end
        bus(32'h20, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h1234_5678) begin
            $display("FAIL read_first_new: got %h want %h", d_data_o, 32'h1234_5678); n_miss++;
        end
    endtask

    task automatic test_back_to_back();
        d_addr_i = 32'h10;
        d_rd_i   = 1'b1;
        @(posedge clk_i);
        #1;
        n_vec++;
        if (d_data_o !== 32'hDEAD_CCAA) begin
            $display("FAIL b2b_first: got %h want %h", d_data_o, 32'hDEAD_CCAA); n_miss++;
        end
        d_addr_i = 32'h20;
        @(posedge clk_i);
        #1;
        d_rd_i = 1'b0;
        n_vec++;
        if (d_data_o !== 32'h1234_5678) begin
            $display("FAIL b2b_second: got %h want %h", d_data_o, 32'h1234_5678); n_miss++;
        end
        idle();
        n_vec++;
        if (d_data_o !== 32'h1234_5678) begin
            $display("FAIL b2b_hold: got %h want %h", d_data_o, 32'h1234_5678); n_miss++;
        end
    endtask

    task automatic test_unmapped();
        bus(32'h0, 32'hCAFE_F00D, 4'hF, 1'b0);
        bus(32'h0, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hCAFE_F00D) begin
            $display("FAIL err_setup: got %h want %h", d_data_o, 32'hCAFE_F00D); n_miss++;
        end
        bus(MEM_WORDS * 4, 32'h1111_1111, 4'hF, 1'b0);
        n_vec++;
        if (d_err_o !== 1'b1) begin
            $display("FAIL err_ram_wr_pulse: got %b want 1", d_err_o); n_miss++;
        end
        idle();
        n_vec++;
        if (d_err_o !== 1'b0) begin
            $display("FAIL err_ram_wr_end: got %b want 0", d_err_o); n_miss++;
        end
        bus(MEM_WORDS * 4, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if ({d_err_o, d_data_o} !== {1'b1, 32'h0}) begin
            $display("FAIL err_ram_rd: got err=%b data=%h want err=1 data=0", d_err_o, d_data_o);
            n_miss++;
        end
        bus(MB + 32'h10, 32'h0000_0055, 4'hF, 1'b0);
        n_vec++;
        if (d_err_o !== 1'b1) begin
            $display("FAIL err_mmio_wr_pulse: got %b want 1", d_err_o); n_miss++;
        end
        idle();
        n_vec++;
        if ({d_err_o, con_valid_o} !== 2'b00) begin
            $display("FAIL err_mmio_wr_end: got err/valid=%b want 00", {d_err_o, con_valid_o});
            n_miss++;
        end
        bus(32'h0, 32'h0, 4'h0, 1'b1);
        bus(MB + 32'h10, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if ({d_err_o, d_data_o} !== {1'b1, 32'h0}) begin
            $display("FAIL err_mmio_rd: got err=%b data=%h want err=1 data=0", d_err_o, d_data_o);
            n_miss++;
        end
        bus(32'h0, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if ({d_err_o, d_data_o} !== {1'b0, 32'hCAFE_F00D}) begin
            $display("FAIL err_ram_intact: got err=%b data=%h want err=0 data=cafef00d",
                     d_err_o, d_data_o); n_miss++;
        end
    endtask

    task automatic test_console();
        con_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) bus(MB, 32'h41 + i, 4'h1, 1'b0);
        n_vec++;
        if ({con_valid_o, con_data_o} !== {1'b1, 8'h41}) begin
            $display("FAIL con_head: got valid=%b data=%h want 1/41", con_valid_o, con_data_o);
            n_miss++;
        end
        bus(MB + 32'h4, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h5) begin
            $display("FAIL con_stat_ovf: got %h want %h", d_data_o, 32'h5); n_miss++;
        end
        con_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({con_valid_o, con_data_o} !== {1'b1, 8'(8'h41 + i)}) begin
                $display("FAIL con_drain_%0d: got valid=%b data=%h want 1/%h",
                         i, con_valid_o, con_data_o, 8'(8'h41 + i)); n_miss++;
            end
            idle();
        end
        n_vec++;
        if ({con_valid_o, con_data_o} !== {1'b0, 8'h00}) begin
            $display("FAIL con_drained: got valid=%b data=%h want 0/00", con_valid_o, con_data_o);
            n_miss++;
        end
        con_ready_i = 1'b0;
        bus(MB + 32'h4, 32'h4, 4'h1, 1'b0);
        bus(MB + 32'h4, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h2) begin
            $display("FAIL con_stat_clr: got %h want %h", d_data_o, 32'h2); n_miss++;
        end
    endtask

    task automatic test_fifo_full_pushpop();
        for (int i = 0; i < 4; i++) bus(MB, 32'h50 + i, 4'h1, 1'b0);
        con_ready_i = 1'b1;
        bus(MB, 32'h54, 4'h1, 1'b0);
        con_ready_i = 1'b0;
        n_vec++;
        if (con_data_o !== 8'h51) begin
            $display("FAIL full_pushpop_head: got %h want 51", con_data_o); n_miss++;
        end
        bus(MB + 32'h4, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h1) begin
            $display("FAIL full_pushpop_stat: got %h want %h", d_data_o, 32'h1); n_miss++;
        end
        con_ready_i = 1'b1;
        repeat (3) idle();
        n_vec++;
        if ({con_valid_o, con_data_o} !== {1'b1, 8'h54}) begin
            $display("FAIL full_pushpop_tail: got valid=%b data=%h want 1/54",
                     con_valid_o, con_data_o); n_miss++;
        end
        idle();
        con_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus(MB, 32'h77, 4'h1, 1'b0);
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (con_valid_o !== 1'b1) begin
            $display("FAIL midrst_setup: got valid=%b want 1", con_valid_o); n_miss++;
        end
        rst_i    = 1'b1;
        d_addr_i = 32'h20;
        d_rd_i   = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        d_rd_i = 1'b0;
        n_vec++;
        if ({con_valid_o, con_data_o, d_data_o, d_err_o} !== {1'b0, 8'h00, 32'h0, 1'b0}) begin
            $display("FAIL midrst_clear: got valid=%b con=%h data=%h err=%b want 0/00/0/0",
                     con_valid_o, con_data_o, d_data_o, d_err_o); n_miss++;
        end
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hDEAD_CCAA) begin
            $display("FAIL midrst_ram_kept: got %h want %h", d_data_o, 32'hDEAD_CCAA); n_miss++;
        end
    endtask

    task automatic test_timer();
        bus(MB + 32'hC, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hFFFF_FFFF) begin
            $display("FAIL mtimecmp_reset: got %h want %h", d_data_o, 32'hFFFF_FFFF); n_miss++;
        end
        bus(MB + 32'h8, 32'h0, 4'hF, 1'b0);
        bus(MB + 32'hC, 32'd20, 4'hF, 1'b0);
        bus(MB + 32'h8, 32'd15, 4'hF, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            idle();
            n_vec++;
            if (timer_irq_o !== (k == 6)) begin
                $display("FAIL timer_irq_k%0d: got %b want %b", k, timer_irq_o, (k == 6));
                n_miss++;
            end
        end
        bus(MB + 32'hC, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'd20) begin
            $display("FAIL mtimecmp_rd: got %h want %h", d_data_o, 32'd20); n_miss++;
        end
        bus(MB + 32'h8, 32'hFFFF_FFFE, 4'hF, 1'b0);
        bus(MB + 32'h8, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hFFFF_FFFE) begin
            $display("FAIL mtime_load: got %h want %h", d_data_o, 32'hFFFF_FFFE); n_miss++;
        end
        bus(MB + 32'h8, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'hFFFF_FFFF) begin
            $display("FAIL mtime_max: got %h want %h", d_data_o, 32'hFFFF_FFFF); n_miss++;
        end
        bus(MB + 32'h8, 32'h0, 4'h0, 1'b1);
        n_vec++;
        if (d_data_o !== 32'h0) begin
            $display("FAIL mtime_wrap: got %h want %h", d_data_o, 32'h0); n_miss++;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        d_addr_i    = '0;
        d_data_i    = '0;
        d_rd_i      = 1'b0;
        d_we_i      = 4'h0;
        con_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        test_reset();
        test_ram();
        test_back_to_back();
        test_unmapped();
        test_console();
        test_fifo_full_pushpop();
        test_reset_mid();
        test_timer();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
